prog_loader: RTL
================

Name: prog_loader

Overview:
- Byte-serial program loader; the write-side counterpart of the CPU's instruction fetch path.
- Receives a framed program image over a valid/ready byte stream.
- Packs every three bytes into one 18-bit instruction word and writes it into program RAM, starting at BASE_ADDR.
- Holds the CPU (o_cpuHold) from the start of a load until the load completes successfully.

Parameters:
- BASE_ADDR, 16'h0000, program-RAM address of the first loaded word.
- ADDR_W, 16, address width; fixed to match the instruction pointer width.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset_n  in  1  synchronous reset, active-low.
- i_start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- i_byte  in  8  stream data byte.
- i_valid  in  1  byte present on i_byte.
- o_ready  out  1  loader accepts i_byte this cycle.
- o_wAddr  out  [0:15]  program-RAM write address.
- o_wData  out  [0:17]  program-RAM write data; bit 0 is the MSB.
- o_wEn  out  1  program-RAM write strobe, one cycle per word.
- o_cpuHold  out  1  CPU clock-enable inhibit / reset hold.
- o_busy  out  1  a load is in progress.
- o_done  out  1  last load succeeded; sticky until the next i_start.
- o_error  out  1  last load failed; sticky until the next i_start.

Behaviour:
- Reset (i_reset_n=0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, including o_cpuHold, o_wAddr and o_wData.
  - Reset asserted mid-load aborts the load immediately; no further o_wEn is issued.
- Byte transfer: a byte is taken only on a cycle where i_valid and o_ready are both 1. o_ready depends on state only, not on i_valid.
- Frame format:
  - LEN_HI, LEN_LO: big-endian 16-bit word count N.
  - Then N groups of three bytes: B0, B1, B2.
  - Then an optional checksum byte (see Optional Feature).
- Word packing:
  - wData[0:1] = B0[1:0]; wData[2:9] = B1; wData[10:17] = B2.
  - B0[7:2] must be 0. A nonzero value sends the state machine to ERR; that word is not written.
- States and transitions:
  - IDLE: o_ready=0. i_start -> S_LENH. On that edge: o_cpuHold=1, o_busy=1, o_done=0, o_error=0, checksum accumulator cleared, address counter = BASE_ADDR.
  - S_LENH: o_ready=1. Take byte -> S_LENL.
  - S_LENL: o_ready=1. Take byte and form N. N=0 -> S_CHK (or S_DONE without the feature); otherwise -> S_B0.
  - S_B0 -> S_B1 -> S_B2: o_ready=1, one byte each.
  - S_WR: exactly one cycle. o_ready=0, o_wEn=1, o_wAddr = current address, o_wData = packed word. Then the address increments and the remaining count decrements. Remaining = 0 -> S_CHK / S_DONE; otherwise -> S_B0.
  - S_DONE: o_cpuHold=0, o_busy=0, o_done=1. i_start -> S_LENH.
  - S_ERR: o_cpuHold stays 1, o_busy=0, o_error=1, o_ready=0. Only i_start or reset leaves this state.
- Latency: o_wEn asserts in the cycle immediately after the handshake of B2.
- Address arithmetic: 16-bit, wraps modulo 2^16. BASE_ADDR=16'hFFFF with N=2 writes 16'hFFFF, then 16'h0000.
- N=65535 is legal; the remaining-word counter is 16 bits.
- i_start while o_busy=1 is ignored.
- The stream may stall for any number of cycles (i_valid=0); state and counters hold.
- o_wAddr and o_wData hold their last values whenever o_wEn=0.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit XOR accumulator covers every accepted byte from LEN_HI through the last B2.
  - S_CHK (o_ready=1) takes one byte. Equal to the accumulator -> S_DONE; mismatch -> S_ERR.
  - Words already written remain in RAM after a mismatch, but o_cpuHold stays 1.
- Not defined:
  - No accumulator and no S_CHK state.
  - After the last S_WR, or after LEN_LO with N=0, the machine goes directly to S_DONE.

Test Plan:
- Reset, then i_start; stream 00 01 03 AB CD (plus checksum 64 if the feature is on) -> one o_wEn with o_wAddr=0000, o_wData=18'h3ABCD; then o_done=1, o_cpuHold=0.
- N=3 with i_valid toggled 1/0 every cycle -> three writes at 0000/0001/0002 with correct data; no write without a completed B2 handshake.
- B0=0x04 in the second word -> first word written, second not; o_error=1, o_cpuHold=1, o_ready=0; a subsequent i_start restarts cleanly.
- BASE_ADDR=FFFF, N=2 -> writes at FFFF then 0000.
- PROG_LOADER_CHECKSUM_EN with checksum 0x65 instead of 0x64 in the first case -> o_error=1, o_done=0, o_cpuHold=1.
- i_reset_n=0 for one cycle after B1 -> no o_wEn; all outputs 0 on the next cycle; i_start accepted afterwards; N=0 goes to S_DONE (S_CHK first if the feature is on).

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: receives a framed program image over a byte stream, packs three bytes per
// 18-bit instruction word and writes it to program RAM. Optional trailing checksum: PROG_LOADER_CHECKSUM_EN.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | after reset; CPU free, waiting for i_start
// S_LENH | expecting high byte of word count
// S_LENL | expecting low byte of word count
// S_B0   | expecting word byte 0 (only bits [1:0] carry data)
// S_B1   | expecting word byte 1
// S_B2   | expecting word byte 2
// S_WR   | single-cycle RAM write of the packed word
// S_CHK  | expecting XOR checksum byte (checksum builds only)
// S_DONE | load succeeded; CPU released
// S_ERR  | load failed; CPU kept in hold
module prog_loader #(
  parameter int              ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [7:0]        i_byte,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [0:ADDR_W-1] o_wAddr,
  output logic [0:17]       o_wData,
  output logic              o_wEn,
  output logic              o_cpuHold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LENH,
    S_LENL,
    S_B0,
    S_B1,
    S_B2,
    S_WR,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } stateT;

  // Where the machine goes once the last word (or an empty image) has been handled.
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam stateT S_TAIL = S_CHK;
`else
  localparam stateT S_TAIL = S_DONE;
`endif

  stateT             stateQ, stateD;
  logic [ADDR_W-1:0] addrQ;
  logic [15:0]       remQ;
  logic [7:0]        lenHiQ;
  logic [1:0]        b0Q;
  logic [7:0]        b1Q;
  logic              take;
  logic              startOk;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csumQ;
`endif

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) stateQ <= S_IDLE;
    else            stateQ <= stateD;
  end

  always_comb begin
    stateD    = stateQ;
    startOk   = 1'b0;
    o_ready   = 1'b0;
    o_wEn     = 1'b0;
    o_busy    = 1'b1;
    o_cpuHold = 1'b1;
    o_done    = 1'b0;
    o_error   = 1'b0;
    case (stateQ)
      S_IDLE: begin
        o_busy    = 1'b0;
        o_cpuHold = 1'b0;
        startOk   = i_start;
        if (i_start) stateD = S_LENH;
      end
      S_LENH: begin
        o_ready = 1'b1;
        if (i_valid) stateD = S_LENL;
      end
      S_LENL: begin
        o_ready = 1'b1;
        if (i_valid) stateD = ({lenHiQ, i_byte} == 16'd0) ? S_TAIL : S_B0;
      end
      S_B0: begin
        o_ready = 1'b1;
        if (i_valid) stateD = (i_byte[7:2] != 6'd0) ? S_ERR : S_B1;
      end
      S_B1: begin
        o_ready = 1'b1;
        if (i_valid) stateD = S_B2;
      end
      S_B2: begin
        o_ready = 1'b1;
        if (i_valid) stateD = S_WR;
      end
      S_WR: begin
        o_wEn  = 1'b1;
        stateD = (remQ == 16'd1) ? S_TAIL : S_B0;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        o_ready = 1'b1;
        if (i_valid) stateD = (i_byte == csumQ) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        o_busy    = 1'b0;
        o_cpuHold = 1'b0;
        o_done    = 1'b1;
        startOk   = i_start;
        if (i_start) stateD = S_LENH;
      end
      S_ERR: begin
        o_busy  = 1'b0;
        o_error = 1'b1;
        startOk = i_start;
        if (i_start) stateD = S_LENH;
      end
      default: stateD = S_IDLE;
    endcase
  end

  assign take = i_valid & o_ready;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      addrQ   <= '0;
      remQ    <= '0;
      lenHiQ  <= '0;
      b0Q     <= '0;
      b1Q     <= '0;
      o_wAddr <= '0;
      o_wData <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csumQ   <= '0;
`endif
    end else begin
      if (startOk) addrQ <= BASE_ADDR;
`ifdef PROG_LOADER_CHECKSUM_EN
      if (startOk) csumQ <= '0;
      else if (take && stateQ != S_CHK) csumQ <= csumQ ^ i_byte;
`endif
      case (stateQ)
        S_LENH: if (take) lenHiQ <= i_byte;
        S_LENL: if (take) remQ <= {lenHiQ, i_byte};
        S_B0:   if (take) b0Q <= i_byte[1:0];
        S_B1:   if (take) b1Q <= i_byte;
        S_B2: begin
          // Write port is loaded here so it is valid throughout S_WR and holds afterwards.
          if (take) begin
            o_wAddr <= addrQ;
            o_wData <= {b0Q, b1Q, i_byte};
          end
        end
        S_WR: begin
          addrQ <= addrQ + ADDR_W'(1);
          remQ  <= remQ - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
